// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and memory.
// The slave view is the arbiter; the master view is its environment.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic [3:0]  m0_wstrb;
  logic [3:0]  m1_wstrb;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        spurious_resp;

  modport slave (
    input  m0_req, m1_req,
    input  m0_addr, m1_addr,
    input  m0_wdata, m1_wdata,
    input  m0_wstrb, m1_wstrb,
    output m0_gnt, m1_gnt,
    output m0_rvalid, m1_rvalid,
    output m0_rdata, m1_rdata,
    output d_req, d_addr,
    output d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    output spurious_resp
  );

  modport master (
    output m0_req, m1_req,
    output m0_addr, m1_addr,
    output m0_wdata, m1_wdata,
    output m0_wstrb, m1_wstrb,
    input  m0_gnt, m1_gnt,
    input  m0_rvalid, m1_rvalid,
    input  m0_rdata, m1_rdata,
    input  d_req, d_addr,
    input  d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    input  spurious_resp
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter with a sticky lock and
// an in-order ID FIFO that steers memory responses back to their owner.
module dmem_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [2:0] CMAX = 3'(MAX_OUTST);
  localparam logic [PW-1:0] PLAST = PW'(MAX_OUTST - 1);

  logic [2:0]    count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          fifo [MAX_OUTST];
  logic          prio;
  logic          lock;
  logic          lock_id;
  logic          spur;

  logic sel;
  logic lock_ok;
  logic any_req;
  logic d_req;
  logic hs;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  // a locked requester that dropped req loses the lock this very cycle
  assign lock_ok = lock && (lock_id ? bus.m1_req : bus.m0_req);
  assign any_req = bus.m0_req || bus.m1_req;

  always_comb begin
    sel = 1'b0;
    if (lock_ok)
      sel = lock_id;
    else if (bus.m0_req && bus.m1_req)
      sel = prio;
    else if (bus.m1_req)
      sel = 1'b1;
  end

  assign d_req = !reset && any_req && (count != CMAX);
  assign hs    = d_req && bus.d_gnt;
  assign pop   = !reset && bus.d_rvalid && (count != 3'd0);
  assign head  = fifo[rptr];

  assign bus.d_req   = d_req;
  assign bus.d_addr  = !d_req ? 32'd0 :
                       (sel ? bus.m1_addr : bus.m0_addr);
  assign bus.d_wdata = !d_req ? 32'd0 :
                       (sel ? bus.m1_wdata : bus.m0_wdata);
  assign bus.d_wstrb = !d_req ? 4'd0 :
                       (sel ? bus.m1_wstrb : bus.m0_wstrb);

  assign bus.m0_gnt    = hs && !sel;
  assign bus.m1_gnt    = hs && sel;
  assign bus.m0_rvalid = pop && !head;
  assign bus.m1_rvalid = pop && head;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.d_rdata : 32'd0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.d_rdata : 32'd0;
  assign bus.spurious_resp = spur;

  always_ff @(posedge clk) begin
    if (hs)
      fifo[wptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 3'd0;
      wptr    <= '0;
      rptr    <= '0;
      prio    <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      spur    <= 1'b0;
    end else begin
      if (hs) begin
        wptr <= nxt(wptr);
        prio <= ~sel;
      end
      if (pop)
        rptr <= nxt(rptr);
      if (hs && !pop)
        count <= count + 3'd1;
      else if (pop && !hs)
        count <= count - 3'd1;
      if (bus.d_rvalid && count == 3'd0)
        spur <= 1'b1;
      if (hs) begin
        lock <= 1'b0;
      end else if (d_req) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end else if (!lock_ok) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 2, giving the maximum number of outstanding granted-but-unanswered transactions (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports m0_req/m1_req, input, 1 each, requester N has a transaction pending.
REQ-005 The block SHALL have ports m0_addr/m1_addr, input, 32 each, the word-aligned byte address.
REQ-006 The block SHALL have ports m0_wdata/m1_wdata, input, 32 each, the lane-aligned write data.
REQ-007 The block SHALL have ports m0_wstrb/m1_wstrb, input, 4 each, the byte write strobes, where 0000 means a read.
REQ-008 The block SHALL have ports m0_gnt/m1_gnt, output, 1 each, the request accepted this cycle.
REQ-009 The block SHALL have ports m0_rvalid/m1_rvalid, output, 1 each, a response for requester N is valid this cycle.
REQ-010 The block SHALL have ports m0_rdata/m1_rdata, output, 32 each, the response data.
REQ-011 The block SHALL have port d_req, output, 1, the request to the data memory.
REQ-012 The block SHALL have ports d_addr/d_wdata/d_wstrb, output, 32/32/4, the forwarded transaction.
REQ-013 The block SHALL have port d_gnt, input, 1, the memory accepts d_req this cycle.
REQ-014 The block SHALL have ports d_rvalid/d_rdata, input, 1/32, the in-order memory response, at least 1 cycle after its grant.
REQ-015 The block SHALL have port spurious_resp, output, 1, a sticky flag set when d_rvalid arrives with nothing outstanding.

Function
REQ-016 The block SHALL track outstanding requester IDs in a FIFO of MAX_OUTST entries with a count register, 0..MAX_OUTST.
REQ-017 The block SHALL define a handshake as d_req && d_gnt, which pushes the winner ID into the FIFO in the same cycle.
REQ-018 The block SHALL drive d_req = 0 whenever count == MAX_OUTST, including in cycles where a pop also occurs.
REQ-019 The block SHALL arbitrate round-robin, and a 1-bit priority register SHALL name the preferred requester.
REQ-020 If only one requester has req high, the block SHALL select that requester.
REQ-021 If both requesters have req high, the block SHALL select the preferred requester.
REQ-022 After each handshake, the priority register SHALL point to the requester that did not win.
REQ-023 The block SHALL apply a lock: when d_req && !d_gnt, it SHALL register the selected ID and keep it selected in later cycles until that handshake completes.
REQ-024 While locked, a higher-priority newcomer SHALL NOT change the selection.
REQ-025 The lock SHALL clear on the handshake.
REQ-026 The lock SHALL also clear if the locked requester drops req, which is a protocol violation; the arbiter SHALL then re-arbitrate in the same cycle.
REQ-027 The block SHALL drive d_addr, d_wdata and d_wstrb from the selected requester, and SHALL drive them to 0 when d_req == 0.
REQ-028 The block SHALL assert mN_gnt = d_req && d_gnt && (selected == N), so that at most one grant is high per cycle.
REQ-029 On d_rvalid with count > 0, the block SHALL pop the FIFO head, assert m<head>_rvalid in the same cycle, and route d_rdata to that requester's rdata.
REQ-030 The block SHALL hold the other requester's rdata at 0 and its rvalid at 0.
REQ-031 When a push and a pop occur in the same cycle, count SHALL be unchanged and FIFO order SHALL be preserved; this case is possible only when count < MAX_OUTST.
REQ-032 On d_rvalid with count == 0, the block SHALL set spurious_resp, pop nothing, assert no mN_rvalid, and leave count unchanged.
REQ-033 The FIFO read and write pointers SHALL wrap modulo MAX_OUTST.
REQ-034 Grant latency SHALL be combinational, 0 cycles from req to gnt when memory is ready and count < MAX_OUTST.
REQ-035 The arbiter SHALL add no cycles on the response path.

Reset
REQ-036 On reset, the block SHALL set count = 0, set both FIFO pointers to 0, clear the lock, set priority to requester 0, and clear spurious_resp.
REQ-037 Because outputs derive from that state, d_req, all gnt and all rvalid outputs SHALL be 0 during reset, and all data outputs SHALL be 0.
REQ-038 A reset applied mid-transaction SHALL discard all outstanding IDs.
REQ-039 A d_rvalid arriving in the first cycle after reset SHALL set spurious_resp.

Verification
REQ-040 Scenario: m0_req = 1, m0_addr = 0x100, m0_wstrb = 0000, d_gnt = 1, response 2 cycles later with rdata 0xDEADBEEF -> m0_gnt high in cycle 0, m0_rvalid high in cycle 2 with m0_rdata = 0xDEADBEEF, and m1 outputs stay 0.
REQ-041 Scenario: both requesters request continuously with d_gnt = 1 and immediate responses -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
REQ-042 Scenario: m1 requests alone, d_gnt = 0 for 3 cycles, m0 raises req in cycle 1 -> d_addr = m1_addr for all 4 cycles and m1_gnt is high in cycle 3 only.
REQ-043 Scenario: MAX_OUTST = 2, three back-to-back grants attempted with no responses -> third d_req is 0 until the first d_rvalid; responses return to their owners in grant order m0, m1.
REQ-044 Scenario: push and pop in the same cycle at count = 1 -> count stays 1 and the next response goes to the second-granted requester.
REQ-045 Scenario: d_rvalid with count = 0, then reset for 1 cycle with 2 transactions outstanding -> spurious_resp is set and cleared by reset; after reset count = 0 and d_req follows new requests.
